// File: rtl/master_port.sv
// master_port: serial bus master. A command captured in IDLE is sent as an
// LSB-first serial address (plus write data for writes); reads then collect
// DATA_WIDTH serial bits qualified by s_valid.
// Optional feature: define MASTER_TIMEOUT_EN to abort reads that wait longer
// than RD_TIMEOUT cycles (done with err). Without it err is tied low.
module master_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  m_valid,
  output logic                  m_ready,
  output logic                  tx_address,
  output logic                  tx_data,
  input  logic                  s_ready,
  input  logic                  s_valid,
  input  logic                  rx_data
);

  localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW = $clog2(MaxW + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StWaitSlv, StSend, StRdWait, StRdRecv, StDone} state_e;

  state_e                state_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q;
  logic [DATA_WIDTH-1:0] wdata_sh_q;
  logic [DATA_WIDTH-2:0] rx_sh_q;
  logic [CntW-1:0]       bit_cnt_q;

  logic                  ld_rw;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  rd_last;
  logic                  tmo_fire;

  assign busy    = (state_q != StIdle);
  assign rx_word = {rx_data, rx_sh_q};
  assign rd_last = s_valid && (bit_cnt_q == DataLast);

`ifdef MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RD_TIMEOUT - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            err_q;
  logic            rd_state;

  assign rd_state = (state_q == StRdWait) || (state_q == StRdRecv);
  // Completion in the final allowed cycle wins over the timeout.
  assign tmo_fire = rd_state && !rd_last && (tmo_cnt_q == TmoLast);
  assign err      = err_q;

  // Count cycles spent waiting for read data; cleared outside the read phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= rd_state ? tmo_cnt_q + TmoW'(1) : '0;
      err_q     <= tmo_fire;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign err      = 1'b0;
`endif

  // Command source for SEND entry: live inputs from IDLE, captured copy from WAIT_SLV.
  always_comb begin
    ld_rw    = rw_q;
    ld_addr  = addr_sh_q;
    ld_wdata = wdata_sh_q;
    if (state_q == StIdle) begin
      ld_rw    = rw;
      ld_addr  = addr;
      ld_wdata = rw ? wdata : '0;
    end
  end

  // Main FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rw_q         <= 1'b0;
      addr_sh_q    <= '0;
      wdata_sh_q   <= '0;
      rx_sh_q      <= '0;
      bit_cnt_q    <= '0;
      rdata        <= '0;
      done         <= 1'b0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      m_valid      <= 1'b0;
      m_ready      <= 1'b0;
      tx_address   <= 1'b0;
      tx_data      <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      done         <= 1'b0;
      unique case (state_q)
        StIdle, StWaitSlv: begin
          if (state_q == StWaitSlv || start) begin
            rw_q <= ld_rw;
            if (s_ready) begin
              state_q      <= StSend;
              m_valid      <= 1'b1;
              tx_address   <= ld_addr[0];
              tx_data      <= ld_wdata[0];
              write_enable <= ld_rw;
              read_enable  <= ~ld_rw;
              bit_cnt_q    <= CntW'(1);
              addr_sh_q    <= ld_addr >> 1;
              wdata_sh_q   <= ld_wdata >> 1;
            end else begin
              state_q    <= StWaitSlv;
              addr_sh_q  <= ld_addr;
              wdata_sh_q <= ld_wdata;
            end
          end
        end
        StSend: begin
          if (bit_cnt_q == AddrLast) begin
            m_valid    <= 1'b0;
            tx_address <= 1'b0;
            tx_data    <= 1'b0;
            bit_cnt_q  <= '0;
            if (rw_q) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRdWait;
              m_ready <= 1'b1;
            end
          end else begin
            // wdata_sh_q zero-fills, so tx_data drops to 0 after DATA_WIDTH bits.
            tx_address <= addr_sh_q[0];
            addr_sh_q  <= addr_sh_q >> 1;
            tx_data    <= wdata_sh_q[0];
            wdata_sh_q <= wdata_sh_q >> 1;
            bit_cnt_q  <= bit_cnt_q + CntW'(1);
          end
        end
        StRdWait, StRdRecv: begin
          if (rd_last) begin
            rdata     <= rx_word;
            state_q   <= StDone;
            done      <= 1'b1;
            m_ready   <= 1'b0;
            bit_cnt_q <= '0;
          end else if (tmo_fire) begin
            state_q   <= StDone;
            done      <= 1'b1;
            m_ready   <= 1'b0;
            bit_cnt_q <= '0;
          end else if (s_valid) begin
            rx_sh_q   <= rx_word[DATA_WIDTH-1:1];
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            state_q   <= StRdRecv;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
